uart_nand_bridge: RTL
=====================

// Module: uart_nand_bridge
// PURPOSE
//  Byte-protocol command front end between simpleuart (register interface) and nand_master.
//  Polls the UART receive register, decodes 2-byte host commands, and pulses nand_master activate/cmd_in.
//  Waits for busy to fall, then returns one status or data byte through the UART transmit register.
//  Replaces the ad-hoc character case-statement in the top-level with a deterministic FSM.
// PARAMETERS
//  ACK_CHAR        8'h4B ("K")   reply after a successful C/D command
//  NAK_CHAR        8'h3F ("?")   reply to an unknown opcode
//  TMO_CHAR        8'h54 ("T")   reply on busy timeout (BRIDGE_TIMEOUT_EN only)
//  TIMEOUT_CYCLES  24'd1200000   max hw_clk cycles busy may stay high (100 ms @ 12 MHz)
// PORTS
//  hw_clk          in   1   system clock, 12 MHz
//  reset           in   1   synchronous, active-high
//  reg_dat_do      in   32  simpleuart rx data; 32'hFFFF_FFFF = no byte, else {24'b0,byte}
//  reg_dat_wait    in   1   simpleuart tx busy; a write is accepted only in a cycle where it is 0
//  reg_dat_re      out  1   rx consume strobe, 1 cycle
//  reg_dat_we      out  1   tx write request, held until accepted
//  reg_dat_di      out  32  tx data {24'b0,byte}
//  nand_busy       in   1   nand_master busy
//  nand_data_out   in   8   nand_master read result
//  nand_activate   out  1   nand_master start strobe, 1 cycle
//  nand_cmd_in     out  8   nand_master command code
//  nand_data_in    out  8   nand_master write data
//  proto_err       out  1   sticky: set on NAK (and on timeout when BRIDGE_TIMEOUT_EN); cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0, reg_dat_di=0, nand_cmd_in=0, nand_data_in=0; FSM -> IDLE; any pending tx is dropped.
//  Protocol, opcode byte then argument byte:
//   'C' a : nand_cmd_in<=a, run command, reply ACK_CHAR
//   'D' a : nand_data_in<=a, no NAND activity, reply ACK_CHAR
//   'X' a : nand_cmd_in<=a, run command, reply nand_data_out sampled in the cycle busy is seen 0
//   other : no argument byte is read; reply NAK_CHAR; set proto_err
//  Rx handshake: a byte is available when reg_dat_do != 32'hFFFF_FFFF. Capture reg_dat_do[7:0] and
//   assert reg_dat_re for exactly 1 cycle, then spend 1 DRAIN cycle with no rx sampling before the next read.
//  FSM states:
//   IDLE      byte available -> latch opcode, re=1 -> DRAIN_OP
//   DRAIN_OP  -> GET_ARG if opcode in {C,D,X}, else -> REPLY with NAK_CHAR
//   GET_ARG   byte available -> latch arg, re=1 -> DRAIN_ARG
//   DRAIN_ARG D: -> REPLY with ACK_CHAR; C/X: -> ISSUE
//   ISSUE     nand_activate=1 for 1 cycle -> ARM
//   ARM       1 guard cycle, busy ignored -> WAIT
//   WAIT      busy==0 -> REPLY (ACK_CHAR, or nand_data_out for X)
//   REPLY     reg_dat_we=1, reg_dat_di={24'b0,byte}; in a cycle with reg_dat_wait==0 -> we=0, -> IDLE
//  Latency: activate rises 2 cycles after the arg byte is available; the reply we rises 1 cycle after busy is seen low.
//  Rx bytes arriving during ISSUE/ARM/WAIT/REPLY stay in simpleuart and are not consumed until IDLE or GET_ARG.
//  No arg timeout: after an opcode, GET_ARG waits indefinitely.
//  Reset asserted mid-command: the FSM aborts in the same cycle; the NAND transfer is not cancelled here.
// CONFIGURATION
//  BRIDGE_TIMEOUT_EN defined: 24-bit counter cleared on entry to ARM, increments in WAIT.
//   At TIMEOUT_CYCLES with busy still 1: -> REPLY with TMO_CHAR and set proto_err.
//  Not defined: no counter logic; WAIT waits indefinitely; TMO_CHAR is unused.
// TESTING
//  1 reset, then rx 'C',8'h01, busy high 50 cycles -> one activate pulse, cmd_in=8'h01, tx 8'h4B 1 cycle after busy falls
//  2 'D',8'hA5 then 'C',8'h02 -> nand_data_in=8'hA5 before activate, two tx 8'h4B, activate pulses exactly once
//  3 'X',8'h05 with nand_data_out=8'h3C at busy fall -> tx 8'h3C
//  4 'Z' -> tx 8'h3F, proto_err=1; the next 'C',8'h01 still completes with 8'h4B
//  5 reg_dat_wait held 1 for 300 cycles during REPLY -> we held, di stable, exactly one accepted write
//  6 BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=100, busy stuck 1 -> tx 8'h54 at about 100 cycles, then IDLE; reset mid-WAIT -> all outputs 0 next cycle

Source files
------------

// File: rtl/uart_nand_bridge.sv
// uart_nand_bridge: turns 2-byte host commands from simpleuart into nand_master
// strobes and returns one status or data byte per command.
// Optional busy watchdog enabled by defining BRIDGE_TIMEOUT_EN.
module uart_nand_bridge #(
  parameter logic [7:0]  ACK_CHAR       = 8'h4B,
  parameter logic [7:0]  NAK_CHAR       = 8'h3F,
  parameter logic [7:0]  TMO_CHAR       = 8'h54,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1200000
) (
  input  logic        i_hw_clk,
  input  logic        i_reset,
  input  logic [31:0] i_reg_dat_do,
  input  logic        i_reg_dat_wait,
  output logic        o_reg_dat_re,
  output logic        o_reg_dat_we,
  output logic [31:0] o_reg_dat_di,
  input  logic        i_nand_busy,
  input  logic [7:0]  i_nand_data_out,
  output logic        o_nand_activate,
  output logic [7:0]  o_nand_cmd_in,
  output logic [7:0]  o_nand_data_in,
  output logic        o_proto_err
);

  localparam logic [7:0] OP_C = 8'h43;
  localparam logic [7:0] OP_D = 8'h44;
  localparam logic [7:0] OP_X = 8'h58;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN_OP,
    GET_ARG,
    DRAIN_ARG,
    ISSUE,
    ARM,
    WAIT,
    REPLY
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_opcode;
  logic [7:0]  r_arg;
  logic [7:0]  r_reply;
  logic [7:0]  r_cmd_in;
  logic [7:0]  r_data_in;
  logic        r_proto_err;

  logic        w_rx_avail;
  logic        w_op_valid;
  logic        w_timeout;
  logic        w_re;
  logic        w_latch_op;
  logic        w_latch_arg;
  logic        w_load_reply;
  logic [7:0]  w_reply_byte;
  logic        w_set_err;
  logic        w_load_cmd;
  logic        w_load_data;

  assign w_rx_avail = (i_reg_dat_do != 32'hFFFF_FFFF);
  assign w_op_valid = (r_opcode == OP_C) || (r_opcode == OP_D) || (r_opcode == OP_X);

`ifdef BRIDGE_TIMEOUT_EN
  logic [23:0] r_tmo_cnt;

  // Watchdog on busy: restarts in the ARM guard cycle and counts every WAIT cycle.
  always_ff @(posedge i_hw_clk) begin
    if (i_reset) begin
      r_tmo_cnt <= 24'd0;
    end else if (r_state == ARM) begin
      r_tmo_cnt <= 24'd0;
    end else if (r_state == WAIT) begin
      r_tmo_cnt <= r_tmo_cnt + 24'd1;
    end
  end

  assign w_timeout = (r_tmo_cnt >= (TIMEOUT_CYCLES - 24'd1));
`else
  // Without the watchdog WAIT never gives up; the limit only matters in the timeout build.
  assign w_timeout = (TIMEOUT_CYCLES == 24'd0) && 1'b0;
`endif

  // Next-state decode plus the one-cycle actions attached to each transition.
  always_comb begin
    w_next       = r_state;
    w_re         = 1'b0;
    w_latch_op   = 1'b0;
    w_latch_arg  = 1'b0;
    w_load_reply = 1'b0;
    w_reply_byte = r_reply;
    w_set_err    = 1'b0;
    w_load_cmd   = 1'b0;
    w_load_data  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rx_avail) begin
          w_re       = 1'b1;
          w_latch_op = 1'b1;
          w_next     = DRAIN_OP;
        end
      end
      DRAIN_OP: begin
        if (w_op_valid) begin
          w_next = GET_ARG;
        end else begin
          w_load_reply = 1'b1;
          w_reply_byte = NAK_CHAR;
          w_set_err    = 1'b1;
          w_next       = REPLY;
        end
      end
      GET_ARG: begin
        if (w_rx_avail) begin
          w_re        = 1'b1;
          w_latch_arg = 1'b1;
          w_next      = DRAIN_ARG;
        end
      end
      DRAIN_ARG: begin
        if (r_opcode == OP_D) begin
          w_load_data  = 1'b1;
          w_load_reply = 1'b1;
          w_reply_byte = ACK_CHAR;
          w_next       = REPLY;
        end else begin
          w_load_cmd = 1'b1;
          w_next     = ISSUE;
        end
      end
      ISSUE: begin
        w_next = ARM;
      end
      ARM: begin
        w_next = WAIT;
      end
      WAIT: begin
        if (!i_nand_busy) begin
          w_load_reply = 1'b1;
          w_reply_byte = (r_opcode == OP_X) ? i_nand_data_out : ACK_CHAR;
          w_next       = REPLY;
        end else if (w_timeout) begin
          w_load_reply = 1'b1;
          w_reply_byte = TMO_CHAR;
          w_set_err    = 1'b1;
          w_next       = REPLY;
        end
      end
      REPLY: begin
        if (!i_reg_dat_wait) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    if (i_reset) begin
      w_re = 1'b0;
    end
  end

  // State register and datapath registers; reset aborts any command in flight.
  always_ff @(posedge i_hw_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_opcode    <= 8'h00;
      r_arg       <= 8'h00;
      r_reply     <= 8'h00;
      r_cmd_in    <= 8'h00;
      r_data_in   <= 8'h00;
      r_proto_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_latch_op) begin
        r_opcode <= i_reg_dat_do[7:0];
      end
      if (w_latch_arg) begin
        r_arg <= i_reg_dat_do[7:0];
      end
      if (w_load_reply) begin
        r_reply <= w_reply_byte;
      end
      if (w_load_cmd) begin
        r_cmd_in <= r_arg;
      end
      if (w_load_data) begin
        r_data_in <= r_arg;
      end
      if (w_set_err) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign o_reg_dat_re    = w_re;
  assign o_reg_dat_we    = (r_state == REPLY);
  assign o_reg_dat_di    = {24'h000000, r_reply};
  assign o_nand_activate = (r_state == ISSUE);
  assign o_nand_cmd_in   = r_cmd_in;
  assign o_nand_data_in  = r_data_in;
  assign o_proto_err     = r_proto_err;

endmodule
